// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, memory-op and memory-stage FSM encodings.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  typedef enum logic [1:0] {MEM_NONE, MEM_READ, MEM_WRITE} mem_op_e;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  function automatic mem_op_e mem_decode(input logic [3:0] icode);
    mem_op_e op;
    case (icode)
      MRMOVQ, RET, POPQ:                      op = MEM_READ;
      RMMOVQ, PUSHQ, CALL:                    op = MEM_WRITE;
      HALT, NOP, CMOVXX, IRMOVQ, OPQ, JXX:    op = MEM_NONE;
      default:                                op = MEM_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-to-memory request and memory-to-writeback response handshake bundle.
interface mem_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valM;
  logic        dmem_error;

  modport master (
    output in_valid, icode, valA, valE, valP, out_ready,
    input  in_ready, out_valid, valM, dmem_error
  );

  modport slave (
    input  in_valid, icode, valA, valE, valP, out_ready,
    output in_ready, out_valid, valM, dmem_error
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// Byte-wide single-port data RAM: combinational read, synchronous write. Contents are not reset.
module dmem_byte_ram #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned AddrW     = $clog2(MEM_BYTES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_access.sv
// Y86-64 SEQ memory stage: decodes the access, checks bounds, and moves 8 bytes
// little-endian through a byte RAM, one byte per cycle, behind valid/ready handshakes.
module mem_access
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);

  localparam int unsigned AddrW   = $clog2(MEM_BYTES);
  localparam logic [63:0] MaxAddr = 64'(MEM_BYTES - 8);

  state_e           state_q, state_d;
  mem_op_e          op_q, req_op;
  logic [AddrW-1:0] addr_q;
  logic [63:0]      data_q, valm_q;
  logic             err_q;
  logic [2:0]       cnt_q;

  logic [63:0]      req_addr, req_data;
  logic             req_fault, accept, last_byte;

  logic             ram_we;
  logic [AddrW-1:0] ram_addr;
  logic [7:0]       ram_wdata, ram_rdata;

  always_comb begin
    req_op    = mem_decode(bus.icode);
    req_addr  = (bus.icode == RET || bus.icode == POPQ) ? bus.valA : bus.valE;
    req_data  = (bus.icode == CALL) ? bus.valP : bus.valA;
    // Unsigned compare also catches addresses that would wrap past 2^64.
    req_fault = (req_op != MEM_NONE) && (req_addr > MaxAddr);
    accept    = bus.in_valid && (state_q == IDLE);
    last_byte = (cnt_q == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (req_op == MEM_NONE || req_fault) ? RESP : ACCESS;
      ACCESS:  if (last_byte) state_d = RESP;
      RESP:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = (state_q == RESP);
    bus.valM       = valm_q;
    bus.dmem_error = err_q;
    ram_we         = (state_q == ACCESS) && (op_q == MEM_WRITE);
    ram_addr       = addr_q + AddrW'(cnt_q);
    ram_wdata      = data_q[{cnt_q, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MEM_NONE;
      addr_q <= '0;
      data_q <= '0;
      valm_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= 3'd0;
    end else if (accept) begin
      op_q   <= req_op;
      addr_q <= req_addr[AddrW-1:0];
      data_q <= req_data;
      valm_q <= '0;
      err_q  <= req_fault;
      cnt_q  <= 3'd0;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + 3'd1;
      if (op_q == MEM_READ) valm_q[{cnt_q, 3'b000} +: 8] <= ram_rdata;
    end
  end

  dmem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .AddrW     (AddrW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of full transactions plus backpressure
// and reset-during-write sequences.
module tb_mem_access;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if bus ();

  mem_access #(
    .MEM_BYTES (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] va;
    logic [63:0] ve;
    logic [63:0] vp;
    int          lat;
    logic [63:0] valm;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                     input logic [63:0] vp, input int lat, input logic [63:0] vm,
                     input logic er);
    vec_t v;
    v.icode = ic; v.va = va; v.ve = ve; v.vp = vp; v.lat = lat; v.valm = vm; v.err = er;
    vecs.push_back(v);
  endtask

  // Full transaction: handshake, scramble inputs, wait for response, accept it.
  task automatic do_req(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] p, output int lat, output logic [63:0] vm,
                        output logic er);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_req", 64'(bus.in_ready), 64'd1);
    bus.icode = ic; bus.valA = a; bus.valE = e; bus.valP = p; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.icode = 4'($urandom);
    bus.valA  = {$urandom, $urandom};
    bus.valE  = {$urandom, $urandom};
    bus.valP  = {$urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    vm = bus.valM;
    er = bus.dmem_error;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] vm;
    logic        er;
    int          seen;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.icode = 4'h0;
    bus.valA = '0; bus.valE = '0; bus.valP = '0;

    #1;
    n_vec++;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_valM", bus.valM, 64'd0);
    chk("reset_dmem_error", 64'(bus.dmem_error), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    add(4'h4, 64'h1122334455667788, 64'h10, 64'h0, 9, 64'h0, 1'b0);
    add(4'h5, 64'h0, 64'h10, 64'h0, 9, 64'h1122334455667788, 1'b0);
    add(4'h8, 64'hDEAD, 64'h1F8, 64'h2A, 9, 64'h0, 1'b0);
    add(4'hB, 64'h1F8, 64'h200, 64'h0, 9, 64'h2A, 1'b0);
    add(4'h5, 64'h0, 64'h3FC, 64'h0, 1, 64'h0, 1'b1);
    add(4'h4, 64'h5555, 64'hFFFFFFFFFFFFFFFC, 64'h0, 1, 64'h0, 1'b1);
    add(4'h5, 64'h0, 64'h10, 64'h0, 9, 64'h1122334455667788, 1'b0);
    add(4'hA, 64'hCAFEF00D12345678, 64'h3F8, 64'h0, 9, 64'h0, 1'b0);
    add(4'h9, 64'h3F8, 64'hFFFFFFFFFFFFFFF0, 64'h0, 9, 64'hCAFEF00D12345678, 1'b0);
    add(4'h6, 64'h0, 64'h10, 64'h0, 1, 64'h0, 1'b0);
    add(4'h5, 64'h0, 64'h3F9, 64'h0, 1, 64'h0, 1'b1);
    add(4'h0, 64'h0, 64'h10, 64'h0, 1, 64'h0, 1'b0);
    add(4'h1, 64'h0, 64'h10, 64'h0, 1, 64'h0, 1'b0);
    add(4'h2, 64'h0, 64'h10, 64'h0, 1, 64'h0, 1'b0);
    add(4'h3, 64'h0, 64'h10, 64'h0, 1, 64'h0, 1'b0);
    add(4'h7, 64'h0, 64'h10, 64'h0, 1, 64'h0, 1'b0);

    foreach (vecs[i]) begin
      do_req(vecs[i].icode, vecs[i].va, vecs[i].ve, vecs[i].vp, lat, vm, er);
      n_vec++;
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_valM", i), vm, vecs[i].valm);
      chk($sformatf("vec%0d_dmem_error", i), 64'(er), 64'(vecs[i].err));
    end

    // Backpressure: response held 3 cycles while a competing request is offered.
    @(negedge clk);
    bus.icode = 4'h5; bus.valE = 64'h10; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.icode = 4'h4; bus.valA = 64'h0; bus.valE = 64'h10;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (!bus.out_valid && seen < 40);
    n_vec++;
    chk("bp_latency", 64'(seen), 64'd9);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_out_valid_c%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp_valM_c%0d", c), bus.valM, 64'h1122334455667788);
      chk($sformatf("bp_in_ready_c%0d", c), 64'(bus.in_ready), 64'd0);
      if (c == 3) bus.out_ready = 1'b1;
      if (c < 3) @(negedge clk);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    do_req(4'h5, 64'h0, 64'h10, 64'h0, lat, vm, er);
    n_vec++;
    chk("bp_no_stray_write", vm, 64'h1122334455667788);

    // Reset during a write: three bytes land, the rest keep the old pattern.
    do_req(4'h4, 64'h0102030405060708, 64'h40, 64'h0, lat, vm, er);
    n_vec++;
    chk("rst_prefill_latency", 64'(lat), 64'd9);
    @(negedge clk);
    bus.icode = 4'h4; bus.valA = 64'hAABBCCDDEEFF0011; bus.valE = 64'h40; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("rst_no_response", 64'(seen), 64'd0);
    chk("rst_in_ready_after", 64'(bus.in_ready), 64'd1);
    do_req(4'h5, 64'h0, 64'h40, 64'h0, lat, vm, er);
    n_vec++;
    chk("rst_partial_bytes", vm, 64'h0102030405FF0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory stage of the Y86-64 SEQ datapath. It consumes execute-stage results (icode, valE) plus valA and valP, and performs the data-memory read or write the instruction requires. Storage is an internal byte-wide RAM, accessed one byte per cycle over 8 cycles in little-endian order. Results (valM, dmem_error) go to the writeback and PC-update stages through a valid/ready handshake.

Parameters:
MEM_BYTES, 1024, data-memory size in bytes; legal addresses are 0..MEM_BYTES-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  execute-stage result valid.
in_ready  output  1  block can accept; equals (state==IDLE).
icode  input  4  instruction code.
valA  input  64  register operand; store data or pop/ret address.
valE  input  64  execute result; effective address.
valP  input  64  next PC; store data for call.
out_valid  output  1  result valid; held until out_ready.
out_ready  input  1  downstream accepts the result.
valM  output  64  read data; 0 for non-reads and on error.
dmem_error  output  1  address fault for this instruction; meaningful only while out_valid is high.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, valM=0, dmem_error=0, byte counter=0.
  - RAM contents are not reset.
- Operation decode, latched at handshake (in_valid & in_ready):
  - READ, addr=valE: mrmovq 4'h5.
  - READ, addr=valA: ret 4'h9, popq 4'hB.
  - WRITE, addr=valE, data=valA: rmmovq 4'h4, pushq 4'hA.
  - WRITE, addr=valE, data=valP: call 4'h8.
  - All other icodes: NONE.
- Address check:
  - Fault when addr > MEM_BYTES-8, with addr treated as unsigned 64-bit. This also covers wrap-around.
  - A faulting access performs no RAM read or write, returns valM=0 and dmem_error=1.
- FSM (states IDLE, ACCESS, RESP). Handshake occurs in cycle T:
  - IDLE -> ACCESS when the op is READ or WRITE with no fault.
  - IDLE -> RESP when the op is NONE or faults; out_valid rises in T+1.
  - ACCESS lasts 8 cycles, T+1..T+8, one per byte k=0..7:
    - WRITE commits RAM[addr+k] = data[8k+7:8k] at the edge ending that cycle.
    - READ captures valM[8k+7:8k] = RAM[addr+k].
  - ACCESS -> RESP after k=7; out_valid rises in T+9.
  - RESP: valM and dmem_error are held stable while out_valid=1 and out_ready=0.
  - RESP -> IDLE on out_ready; out_valid=0 next cycle.
- in_ready is low in ACCESS and RESP. No new request is accepted in the same cycle as a RESP handshake.
- valM is cleared to 0 at acceptance of every new request.
- Inputs are sampled only at handshake; later changes on icode/valA/valE/valP are ignored.
- Reset mid-ACCESS: operation aborts immediately. Bytes already committed stay in RAM; remaining bytes are not written. No out_valid is produced for the aborted request.
- Byte counter is 3 bits and is never observed outside ACCESS.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - Memory op enum: MEM_NONE, MEM_READ, MEM_WRITE.
  - FSM state enum.
- One sub-module, dmem_byte_ram:
  - MEM_BYTES x 8 array.
  - Single port; combinational read, synchronous write with write-enable.
  - Address width $clog2(MEM_BYTES).

Test Plan:
- rmmovq: icode=4, valE=0x10, valA=0x1122334455667788 -> out_valid at T+9, dmem_error=0, RAM[0x10]=0x88, RAM[0x17]=0x11. Then mrmovq: icode=5, valE=0x10 -> valM=0x1122334455667788 at T+9.
- call then popq: icode=8, valE=0x1F8, valP=0x2A -> RAM[0x1F8..0x1FF]=2A 00 00 00 00 00 00 00. Then icode=B, valA=0x1F8 (valE=0x200) -> valM=0x2A.
- Faults:
  - icode=5, valE=0x3FC (MEM_BYTES=1024) -> out_valid at T+1, dmem_error=1, valM=0.
  - icode=4, valE=0xFFFFFFFFFFFFFFFC -> dmem_error=1, RAM unchanged.
- Non-memory op: icode=6 -> out_valid at T+1, valM=0, dmem_error=0. Then cycle the same flow for icode=0, 1, 2, 3, 7 with identical results.
- Backpressure: out_ready=0 for 3 cycles after a read response -> out_valid and valM stable, in_ready=0. Accept on the 4th cycle -> in_ready=1 the next cycle.
- Reset mid-write: icode=4, valE=0x40, valA=0xAABBCCDDEEFF0011, rst_n low in T+4 -> out_valid=0 immediately, in_ready=1 after release. RAM[0x40..0x42]=11 00 FF; RAM[0x43..0x47] retain their prior values.
